// File: rtl/id_ex_stage_reg_if.sv
// Decode-to-execute bus: everything the decode stage hands to the ID/EX register.
// The decode logic drives it as master; the stage register consumes it as slave.
interface id_ex_stage_reg_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 14
);
    logic              valid_d;
    logic [XLEN-1:0]   instr_d;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   pcplus4_d;
    logic [XLEN-1:0]   imm_d;
    logic [XLEN-1:0]   rd1_d;
    logic [XLEN-1:0]   rd2_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic              branch_d;
    logic              memread_d;

    modport master (
        output valid_d, instr_d, pc_d, pcplus4_d, imm_d,
               rd1_d, rd2_d, ctrl_d, branch_d, memread_d
    );

    modport slave (
        input valid_d, instr_d, pc_d, pcplus4_d, imm_d,
              rd1_d, rd2_d, ctrl_d, branch_d, memread_d
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall/flush, writeback bypass and stall-time operand
// refresh, load-use hazard detection, static-taken branch target and event counters.
module id_ex_stage_reg #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 14,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    id_ex_stage_reg_if.slave  dec,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   instr_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pcplus4_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [4:0]        rd_e,
    output logic [4:0]        rs1_e,
    output logic [4:0]        rs2_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic              branch_e,
    output logic              memread_e,
    output logic              valid_e,
    output logic [4:0]        rs1_d,
    output logic [4:0]        rs2_d,
    output logic [XLEN-1:0]   predict_addr,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic       wb_live;
    logic       bypass1;
    logic       bypass2;
    logic       refresh1;
    logic       refresh2;
    logic [4:0] rd_d;

    assign rs1_d = dec.instr_d[19:15];
    assign rs2_d = dec.instr_d[24:20];
    assign rd_d  = dec.instr_d[11:7];

    // x0 is hardwired zero, so a writeback to it must never reach an operand
    assign wb_live  = wb_we && (wb_rd != 5'd0);
    assign bypass1  = wb_live && (wb_rd == rs1_d);
    assign bypass2  = wb_live && (wb_rd == rs2_d);
    assign refresh1 = wb_live && (wb_rd == rs1_e);
    assign refresh2 = wb_live && (wb_rd == rs2_e);

    assign predict_addr = dec.branch_d ? (dec.pc_d + dec.imm_d) : dec.pcplus4_d;

    assign load_use_stall = valid_e && memread_e && (rd_e != 5'd0) && dec.valid_d &&
                            ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || flush_e) begin
            instr_e   <= '0;
            pc_e      <= '0;
            pcplus4_e <= '0;
            imm_e     <= '0;
            rd1_e     <= '0;
            rd2_e     <= '0;
            rd_e      <= '0;
            rs1_e     <= '0;
            rs2_e     <= '0;
            ctrl_e    <= '0;
            branch_e  <= 1'b0;
            memread_e <= 1'b0;
            valid_e   <= 1'b0;
        end else if (stall_e) begin
            // A held instruction may be waiting on a register that retires now
            if (refresh1) rd1_e <= wb_data;
            if (refresh2) rd2_e <= wb_data;
        end else begin
            instr_e   <= dec.instr_d;
            pc_e      <= dec.pc_d;
            pcplus4_e <= dec.pcplus4_d;
            imm_e     <= dec.imm_d;
            rd1_e     <= bypass1 ? wb_data : dec.rd1_d;
            rd2_e     <= bypass2 ? wb_data : dec.rd2_d;
            rd_e      <= rd_d;
            rs1_e     <= rs1_d;
            rs2_e     <= rs2_d;
            ctrl_e    <= dec.ctrl_d;
            branch_e  <= dec.branch_d;
            memread_e <= dec.memread_d;
            valid_e   <= dec.valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush_e && dec.valid_d && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
            if (stall_e && !flush_e && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
